// File: rtl/pc_seq_pkg.sv
// Shared constants and next-PC select encoding for the fetch-stage PC sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_WIDTH        = 32;
    localparam int unsigned PC_STEP         = 4;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_RET   = 3'd1,
        SEL_CALL  = 3'd2,
        SEL_BR    = 3'd3,
        SEL_SEQ   = 3'd4,
        SEL_RESET = 3'd5
    } pc_sel_e;

    // Priority: reset > stall > ret > call > branch > sequential.
    function automatic pc_sel_e pick_sel(input logic reset, input logic stall,
                                         input logic ret, input logic call,
                                         input logic br_taken);
        pc_sel_e sel;
        sel = SEL_SEQ;
        if (reset)         sel = SEL_RESET;
        else if (stall)    sel = SEL_HOLD;
        else if (ret)      sel = SEL_RET;
        else if (call)     sel = SEL_CALL;
        else if (br_taken) sel = SEL_BR;
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_link_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
module link_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf_pulse,
    output logic             udf_pulse
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign top_ptr   = ptr_q - 1'b1;
    assign top       = mem_q[top_ptr];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && !pop;
    assign ovf_pulse = do_push && full;
    assign udf_pulse = pop && empty;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            ptr_d = top_ptr;
            cnt_d = cnt_q - 1'b1;
        end else if (do_push) begin
            ptr_d = ptr_q + 1'b1;
            if (!full) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[ptr_q] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with stall, branch redirect and call/return via link stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     WIDTH        = PC_WIDTH,
    parameter int unsigned     STEP         = PC_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int unsigned     DEPTH        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             overflow_err,
    output logic             underflow_err
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] stk_top;
    logic             stk_empty, stk_full, ovf_pulse, udf_pulse;
    logic             ovf_q, ovf_d, udf_q, udf_d;

    assign sel     = pick_sel(reset, stall, ret, call, br_taken);
    assign pc_plus = pc_q + WIDTH'(STEP);

    link_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_link_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (sel == SEL_CALL),
        .pop       (sel == SEL_RET),
        .push_data (pc_plus),
        .top       (stk_top),
        .empty     (stk_empty),
        .full      (stk_full),
        .ovf_pulse (ovf_pulse),
        .udf_pulse (udf_pulse)
    );

    always_comb begin
        pc_d = pc_plus;
        unique case (sel)
            SEL_RESET: pc_d = RESET_VECTOR;
            SEL_HOLD:  pc_d = pc_q;
            // A ret on an empty stack falls through to sequential fetch.
            SEL_RET:   pc_d = stk_empty ? pc_plus : stk_top;
            SEL_CALL:  pc_d = br_target;
            SEL_BR:    pc_d = br_target;
            default:   pc_d = pc_plus;
        endcase
    end

    assign ovf_d = ovf_q | ovf_pulse;
    assign udf_d = udf_q | udf_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign pc_out        = pc_q;
    assign stack_empty   = stk_empty;
    assign stack_full    = stk_full;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic vs a queue model.
module tb_pc_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, call, ret;
    logic [31:0] br_target;
    logic [31:0] pc_out, pc_plus;
    logic        stack_empty, stack_full, overflow_err, underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    bit          m_ovf, m_udf;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit b, input bit c,
                              input bit rt, input logic [31:0] t);
        if (r) begin
            m_pc = RV;
            m_stk.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (s) begin
            // nothing changes
        end else if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = m_pc + 32'd4;
                m_udf = 1;
            end
        end else if (c) begin
            if (m_stk.size() == DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1;
            end
            m_stk.push_back(m_pc + 32'd4);
            m_pc = t;
        end else if (b) begin
            m_pc = t;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_out,                 m_pc);
        chk({tag, ".plus"},  pc_plus,                m_pc + 32'd4);
        chk({tag, ".empty"}, {31'd0, stack_empty},   {31'd0, m_stk.size() == 0});
        chk({tag, ".full"},  {31'd0, stack_full},    {31'd0, m_stk.size() == DEPTH});
        chk({tag, ".ovf"},   {31'd0, overflow_err},  {31'd0, m_ovf});
        chk({tag, ".udf"},   {31'd0, underflow_err}, {31'd0, m_udf});
    endtask

    task automatic step(input string tag, input bit r, input bit s, input bit b,
                        input bit c, input bit rt, input logic [31:0] t);
        reset = r; stall = s; br_taken = b; call = c; ret = rt; br_target = t;
        @(posedge clk);
        model_edge(r, s, b, c, rt, t);
        #1;
        check_all(tag);
    endtask

    task automatic seq(input string tag);
        step(tag, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        reset = 1; stall = 0; br_taken = 0; call = 0; ret = 0; br_target = '0;
        m_pc = RV; m_ovf = 0; m_udf = 0;

        // Reset and free-run
        step("rst", 1, 0, 0, 0, 0, 32'h0);
        chk("rst.pc_const", pc_out, 32'h0);
        chk("rst.plus_const", pc_plus, 32'h4);
        seq("run1"); seq("run2"); seq("run3");
        chk("run3.pc_const", pc_out, 32'hC);

        // Branch from 0x100 to 0x2000
        step("br_setup", 0, 0, 1, 0, 0, 32'h100);
        step("br", 0, 0, 1, 0, 0, 32'h2000);
        chk("br.pc_const", pc_out, 32'h2000);
        seq("br_seq");
        chk("br_seq.pc_const", pc_out, 32'h2004);

        // Call at 0x40, two sequential cycles, ret
        step("call_setup", 0, 0, 1, 0, 0, 32'h40);
        step("call", 0, 0, 0, 1, 0, 32'h800);
        seq("call_s1"); seq("call_s2");
        step("ret", 0, 0, 0, 0, 1, 32'h0);
        chk("ret.pc_const", pc_out, 32'h44);
        chk("ret.empty_const", {31'd0, stack_empty}, 32'h1);

        // Five nested calls then five rets
        for (int i = 0; i < 5; i++) step("ncall", 0, 0, 0, 1, 0, 32'h1000 * (i + 1));
        chk("ncall.ovf_const", {31'd0, overflow_err}, 32'h1);
        for (int i = 0; i < 5; i++) step("nret", 0, 0, 0, 0, 1, 32'h0);
        chk("nret.udf_const", {31'd0, underflow_err}, 32'h1);

        // Stall drops branch; ret+call pops exactly one
        step("stall_br", 0, 1, 1, 0, 0, 32'h7770);
        step("c1", 0, 0, 0, 1, 0, 32'h300);
        step("c2", 0, 0, 0, 1, 0, 32'h400);
        step("retcall", 0, 0, 1, 1, 1, 32'h900);
        step("ret_after", 0, 0, 0, 0, 1, 32'h0);
        step("ret_empty_chk", 0, 0, 0, 0, 0, 32'h0);

        // Wrap-around
        step("wrap_setup", 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        seq("wrap");
        chk("wrap.pc_const", pc_out, 32'h0);

        // Reset mid-stall with three entries
        step("rs_rst", 1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("rs_call", 0, 0, 0, 1, 0, 32'h500 + 32'(i * 16));
        step("rs_stall", 0, 1, 0, 1, 0, 32'h0);
        step("rs_reset", 1, 1, 1, 1, 1, 32'h1234);
        chk("rs_reset.pc_const", pc_out, RV);
        chk("rs_reset.empty_const", {31'd0, stack_empty}, 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, s, b, c, rt;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 9) == 0);
            b  = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 5) == 0);
            rt = ($urandom_range(0, 5) == 0);
            step("rand", r, s, b, c, rt, {$urandom()} & 32'hFFFF_FFFC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the pipelined control unit, replacing the fixed PC+4 adder. It holds the architectural PC and advances it by a configurable step each cycle. It also supports pipeline stall, taken-branch redirect, and call/return through an internal circular link stack. It sits at the fetch stage and feeds instruction memory and the IF/ID pipeline register.

## Interface
- WIDTH, 32, address width in bits
- STEP, 4, sequential increment in bytes
- RESET_VECTOR, 0, PC value loaded on reset
- DEPTH, 4, link-stack entries (power of two, ≥2)

Ports:
- clk  input  1  rising-edge clock (the only clock)
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and stack; all other requests ignored this cycle
- br_taken  input  1  redirect to br_target
- br_target  input  WIDTH  branch/call destination
- call  input  1  push pc_plus, then redirect to br_target
- ret  input  1  pop link stack and redirect to popped address
- pc_out  output  WIDTH  current PC (registered)
- pc_plus  output  WIDTH  pc_out + STEP (combinational)
- stack_empty  output  1  no valid link entries
- stack_full  output  1  DEPTH valid entries
- overflow_err  output  1  sticky; a call overwrote the oldest entry
- underflow_err  output  1  sticky; a ret was made with the stack empty

## Operation
- Arithmetic: pc_plus = (pc_out + STEP) mod 2^WIDTH. Carry is discarded, so wrap-around is silent.
- Next-PC priority, evaluated each rising edge, highest first:
  - reset: pc_out←RESET_VECTOR, stack pointer←0, count←0, both error flags←0.
  - stall: every register holds. br_taken/call/ret are dropped, not queued; upstream re-presents them.
  - ret: non-empty stack → pc_out←top entry, pointer−1, count−1. Empty stack → pc_out←pc_plus and underflow_err←1.
  - call: entry[pointer]←pc_plus, pointer+1 (mod DEPTH), count saturates at DEPTH, pc_out←br_target. Calling when full overwrites the oldest entry and sets overflow_err←1.
  - br_taken (no call): pc_out←br_target; stack unchanged.
  - default: pc_out←pc_plus.
- Simultaneous events:
  - ret+call: ret wins, call is dropped entirely (no push).
  - call+br_taken: treated as a call.
  - ret+br_taken: ret wins.
- Status outputs: stack_empty = (count==0). stack_full = (count==DEPTH). Both are derived from registered count.
- Error flags clear only on reset.

## Timing
- Reset values: pc_out=RESET_VECTOR, pc_plus=RESET_VECTOR+STEP, stack_empty=1, stack_full=0, overflow_err=0, underflow_err=0.
- Redirect latency is one cycle: a request sampled at edge N is visible on pc_out after edge N.
- pc_plus follows pc_out combinationally in the same cycle.
- A push at edge N can be popped at edge N+1; back-to-back call/ret returns the just-pushed address.
- A reset asserted mid-sequence (e.g. while stalled or with requests pending) takes effect at the next edge and discards stack contents.
- Stall has no latency cost on release: the cycle after stall deasserts behaves as if the stall never occurred.

## Structure
- Shared package pc_seq_pkg:
  - default constants (PC_WIDTH=32, PC_STEP=4, PC_RESET_VECTOR=0)
  - next-PC select enumeration: SEL_HOLD, SEL_RET, SEL_CALL, SEL_BR, SEL_SEQ, SEL_RESET
- Sub-module link_stack (circular LIFO, DEPTH×WIDTH) owns:
  - pointer, count and entry storage
  - the overwrite-on-full and underflow behaviour
  - push, pop, top, empty, full and the two error pulses
- pc_sequencer owns the PC register, the priority select and the sticky flags.

## Test plan
- Reset, then 3 free-running cycles, RESET_VECTOR=0 → pc_out sequence 0, 4, 8, 12; stack_empty=1.
- pc_out=0x100, br_taken=1, br_target=0x2000 → next pc_out=0x2000, then 0x2004; stack untouched.
- pc_out=0x40, call to 0x800, two sequential cycles, then ret → pc_out 0x800, 0x804, 0x808, 0x44; stack_empty=1 afterwards.
- DEPTH=4, 5 nested calls then 5 rets → overflow_err=1 after the 5th call. The first 4 rets return the newest 4 links. The 5th ret goes sequential (pc_plus) with underflow_err=1.
- stall=1 with br_taken=1 → pc_out holds. ret and call asserted together → ret taken, count decrements by exactly 1.
- pc_out=0xFFFF_FFFC, no request → pc_out wraps to 0x0. reset asserted mid-stall with stack count 3 → next cycle pc_out=RESET_VECTOR, stack_empty=1, flags 0.
